alu_arbiter: RTL and testbench

//  Shares the single combinational 8-bit ALU between two requesters (r0, r1), e.g. the control

---
 rtl/alu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
// Optional ALU_ARB_PERF_EN adds 16-bit per-requester response counters r0_count/r1_count.
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int MAX_OP = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_op1,
  input  logic [DATA_W-1:0] r0_op2,
  input  logic [OP_W-1:0]   r0_opcode,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic [DATA_W-1:0] r0_result,
  output logic              r0_err,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_op1,
  input  logic [DATA_W-1:0] r1_op2,
  input  logic [OP_W-1:0]   r1_opcode,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] r1_result,
  output logic              r1_err,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  output logic [OP_W-1:0]   alu_operation,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_result
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]       r0_count,
  output logic [15:0]       r1_count
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q;
  logic              prio_q;
  logic              owner_q;
  logic [DATA_W-1:0] alu_op1_q, alu_op2_q;
  logic [OP_W-1:0]   alu_opc_q;
  logic              alu_en_q;
  logic              r0_rsp_valid_q, r1_rsp_valid_q;
  logic [DATA_W-1:0] r0_result_q, r1_result_q;
  logic              r0_err_q, r1_err_q;

  logic              grant_d;
  logic              accept_d;
  logic              legal_d;
  logic              rsp_hs_d;
  logic [DATA_W-1:0] op1_d, op2_d;
  logic [OP_W-1:0]   opc_d;

  // prio_q only matters when both requesters are valid in the same cycle
  always_comb begin
    grant_d  = (r0_valid && r1_valid) ? prio_q : r1_valid;
    op1_d    = grant_d ? r1_op1 : r0_op1;
    op2_d    = grant_d ? r1_op2 : r0_op2;
    opc_d    = grant_d ? r1_opcode : r0_opcode;
    legal_d  = (opc_d <= OP_W'(MAX_OP));
    rsp_hs_d = (state_q == RESP) && (owner_q ? r1_rsp_ready : r0_rsp_ready);
  end

  assign r0_ready = rst_n && (state_q == IDLE) && r0_valid && !grant_d;
  assign r1_ready = rst_n && (state_q == IDLE) && r1_valid && grant_d;
  assign accept_d = r0_ready || r1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      prio_q         <= 1'b0;
      owner_q        <= 1'b0;
      alu_op1_q      <= '0;
      alu_op2_q      <= '0;
      alu_opc_q      <= '0;
      alu_en_q       <= 1'b0;
      r0_rsp_valid_q <= 1'b0;
      r1_rsp_valid_q <= 1'b0;
      r0_result_q    <= '0;
      r1_result_q    <= '0;
      r0_err_q       <= 1'b0;
      r1_err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            owner_q <= grant_d;
            prio_q  <= ~grant_d;
            if (legal_d) begin
              alu_op1_q <= op1_d;
              alu_op2_q <= op2_d;
              alu_opc_q <= opc_d;
              alu_en_q  <= 1'b1;
              state_q   <= ISSUE;
            end else begin
              // illegal opcode skips the ALU entirely and answers next cycle
              if (grant_d) begin
                r1_result_q    <= '0;
                r1_err_q       <= 1'b1;
                r1_rsp_valid_q <= 1'b1;
              end else begin
                r0_result_q    <= '0;
                r0_err_q       <= 1'b1;
                r0_rsp_valid_q <= 1'b1;
              end
              state_q <= RESP;
            end
          end
        end
        ISSUE: begin
          alu_en_q <= 1'b0;
          if (owner_q) begin
            r1_result_q    <= alu_result;
            r1_err_q       <= 1'b0;
            r1_rsp_valid_q <= 1'b1;
          end else begin
            r0_result_q    <= alu_result;
            r0_err_q       <= 1'b0;
            r0_rsp_valid_q <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_hs_d) begin
            if (owner_q) r1_rsp_valid_q <= 1'b0;
            else         r0_rsp_valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_operand1  = alu_op1_q;
  assign alu_operand2  = alu_op2_q;
  assign alu_operation = alu_opc_q;
  assign alu_enable    = alu_en_q;
  assign r0_rsp_valid  = r0_rsp_valid_q;
  assign r1_rsp_valid  = r1_rsp_valid_q;
  assign r0_result     = r0_result_q;
  assign r1_result     = r1_result_q;
  assign r0_err        = r0_err_q;
  assign r1_err        = r1_err_q;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] r0_cnt_q, r1_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_cnt_q <= '0;
      r1_cnt_q <= '0;
    end else if (rsp_hs_d) begin
      if (owner_q) r1_cnt_q <= r1_cnt_q + 16'd1;
      else         r0_cnt_q <= r0_cnt_q + 16'd1;
    end
  end

  assign r0_count = r0_cnt_q;
  assign r1_count = r1_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU and arbiter model
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int MAXOP = 6;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] opc;
  } req_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_err;
  logic       r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_err;
  logic [7:0] r0_op1, r0_op2, r0_result, r1_op1, r1_op2, r1_result;
  logic [2:0] r0_opcode, r1_opcode;
  logic [7:0] alu_operand1, alu_operand2, alu_result;
  logic [2:0] alu_operation;
  logic       alu_enable;
`ifdef ALU_ARB_PERF_EN
  logic [15:0] r0_count, r1_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  req_t pend0[$];
  req_t pend1[$];
  int   acc_cyc[$];
  int   acc_who[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[2:0];
      3'd6: return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(alu_operand1, alu_operand2, alu_operation);

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op1(r0_op1), .r0_op2(r0_op2),
    .r0_opcode(r0_opcode), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_result(r0_result), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op1(r1_op1), .r1_op2(r1_op2),
    .r1_opcode(r1_opcode), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_result(r1_result), .r1_err(r1_err),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_operation(alu_operation), .alu_enable(alu_enable), .alu_result(alu_result)
`ifdef ALU_ARB_PERF_EN
    , .r0_count(r0_count), .r1_count(r1_count)
`endif
  );

  task automatic idle_inputs();
    r0_valid = 0; r0_op1 = 0; r0_op2 = 0; r0_opcode = 0; r0_rsp_ready = 0;
    r1_valid = 0; r1_op1 = 0; r1_op2 = 0; r1_opcode = 0; r1_rsp_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    r0_valid = 1; r1_valid = 1;
    @(negedge clk);
    n_checks++;
    if ({r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_result, r1_result, r0_err, r1_err,
         alu_operand1, alu_operand2, alu_operation, alu_enable} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: readies=%b%b enable=%b got nonzero, expected all 0", r0_ready, r1_ready, alu_enable);
    end
    r0_valid = 0; r1_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    n_checks++;
    if ({r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, alu_enable} !== 5'b0) begin
      n_fail++; $display("FAIL reset_release: got %b expected 00000", {r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, alu_enable});
    end
  endtask

  task automatic test_single_op();
    r0_rsp_ready = 1;
    @(posedge clk); #1;
    r0_valid = 1; r0_op1 = 8'h0D; r0_op2 = 8'h03; r0_opcode = 3'b000;
    @(negedge clk);
    n_checks++;
    if ({r0_ready, r1_ready, alu_enable} !== 3'b100) begin
      n_fail++; $display("FAIL single_accept: ready0/ready1/en=%b expected 100", {r0_ready, r1_ready, alu_enable});
    end
    @(posedge clk); #1 r0_valid = 0;
    @(negedge clk);
    n_checks++;
    if ({alu_enable, alu_operand1, alu_operand2, alu_operation, r0_rsp_valid} !== {1'b1, 8'h0D, 8'h03, 3'b000, 1'b0}) begin
      n_fail++; $display("FAIL single_issue: en=%b op1=%h op2=%h opc=%0d rv=%b expected 1 0d 03 0 0",
                         alu_enable, alu_operand1, alu_operand2, alu_operation, r0_rsp_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({r0_rsp_valid, r0_result, r0_err, alu_enable, r1_rsp_valid} !== {1'b1, 8'h10, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_resp: rv=%b res=%h err=%b en=%b rv1=%b expected 1 10 0 0 0",
                         r0_rsp_valid, r0_result, r0_err, alu_enable, r1_rsp_valid);
    end
    @(negedge clk);
    n_checks++;
    if (r0_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_consumed: rsp_valid=%b expected 0", r0_rsp_valid);
    end
    r0_rsp_ready = 0;
  endtask

  // Cycle-by-cycle model of the arbitration contract, fed from pend0/pend1
  task automatic run_traffic(input bit rnd, input string tag);
    int   total = pend0.size() + pend1.size();
    int   ndone = 0, budget = 0, own = 0, acc_c = 0, due = 0, prio = 0, g;
    bit   busy = 0, leg = 0, eerr = 0, exp_en, expv;
    logic [1:0] dv = 2'b00, took = 2'b00, rr, exp_rdy, rv;
    logic [7:0] eres;
    logic [7:0] res[2];
    logic       er[2];
    req_t cur[2];
    req_t oreq;
    acc_cyc.delete(); acc_who.delete();
    while (ndone < total && budget < 5000) begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (took[r]) dv[r] = 1'b0;
        if (!dv[r] && (!rnd || $urandom_range(0, 2) != 0)) begin
          if (r == 0 && pend0.size() > 0) begin cur[0] = pend0.pop_front(); dv[0] = 1'b1; end
          if (r == 1 && pend1.size() > 0) begin cur[1] = pend1.pop_front(); dv[1] = 1'b1; end
        end
      end
      took = 2'b00;
      rr = rnd ? 2'($urandom_range(0, 3)) : 2'b11;
      r0_valid = dv[0]; r0_op1 = cur[0].a; r0_op2 = cur[0].b; r0_opcode = cur[0].opc;
      r1_valid = dv[1]; r1_op1 = cur[1].a; r1_op2 = cur[1].b; r1_opcode = cur[1].opc;
      r0_rsp_ready = rr[0]; r1_rsp_ready = rr[1];
      @(negedge clk);
      budget++;
      exp_rdy = 2'b00;
      if (!busy) begin
        if (dv == 2'b11) exp_rdy[prio] = 1'b1;
        else exp_rdy = dv;
      end
      n_checks++;
      if ({r1_ready, r0_ready} !== exp_rdy) begin
        n_fail++; $display("FAIL %s ready: got %b expected %b at cycle %0d", tag, {r1_ready, r0_ready}, exp_rdy, cyc);
      end
      exp_en = busy && leg && (cyc == acc_c + 1);
      n_checks++;
      if (alu_enable !== exp_en) begin
        n_fail++; $display("FAIL %s alu_enable: got %b expected %b at cycle %0d", tag, alu_enable, exp_en, cyc);
      end
      if (exp_en) begin
        n_checks++;
        if ({alu_operand1, alu_operand2, alu_operation} !== {oreq.a, oreq.b, oreq.opc}) begin
          n_fail++; $display("FAIL %s alu_bus: got %h/%h/%0d expected %h/%h/%0d", tag,
                             alu_operand1, alu_operand2, alu_operation, oreq.a, oreq.b, oreq.opc);
        end
      end
      rv = {r1_rsp_valid, r0_rsp_valid};
      res[0] = r0_result; res[1] = r1_result;
      er[0] = r0_err;     er[1] = r1_err;
      for (int r = 0; r < 2; r++) begin
        expv = busy && (own == r) && (cyc >= due);
        n_checks++;
        if (rv[r] !== expv) begin
          n_fail++; $display("FAIL %s rsp_valid%0d: got %b expected %b at cycle %0d", tag, r, rv[r], expv, cyc);
        end
        if (expv) begin
          n_checks++;
          if ({res[r], er[r]} !== {eres, eerr}) begin
            n_fail++; $display("FAIL %s result%0d: got %h err %b expected %h err %b", tag, r, res[r], er[r], eres, eerr);
          end
          if (rr[r]) begin busy = 0; ndone++; end
        end
      end
      if (exp_rdy != 2'b00) begin
        g = exp_rdy[1] ? 1 : 0;
        oreq = cur[g];
        leg  = (oreq.opc <= MAXOP);
        eres = leg ? alu_f(oreq.a, oreq.b, oreq.opc) : 8'h00;
        eerr = !leg;
        busy = 1; own = g; acc_c = cyc; due = cyc + (leg ? 2 : 1);
        prio = 1 - g;
        took[g] = 1'b1;
        acc_cyc.push_back(cyc); acc_who.push_back(g);
      end
    end
    n_checks++;
    if (ndone != total) begin
      n_fail++; $display("FAIL %s timeout: responses %0d expected %0d", tag, ndone, total);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_sweep();
    req_t q;
    do_reset();
    for (int i = 0; i <= MAXOP; i++) begin
      q.a = 8'($urandom); q.b = 8'($urandom); q.opc = 3'(i);
      pend0.push_back(q);
    end
    run_traffic(1'b0, "sweep");
    n_checks++;
    if (acc_cyc.size() != 7) begin
      n_fail++; $display("FAIL sweep_count: accepts %0d expected 7", acc_cyc.size());
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
        n_fail++; $display("FAIL sweep_spacing: gap %0d expected 3", acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

  task automatic test_contention();
    req_t q;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q.a = 8'($urandom); q.b = 8'($urandom); q.opc = 3'($urandom_range(0, MAXOP)); pend0.push_back(q);
      q.a = 8'($urandom); q.b = 8'($urandom); q.opc = 3'($urandom_range(0, MAXOP)); pend1.push_back(q);
    end
    run_traffic(1'b0, "contention");
    for (int i = 0; i < acc_who.size(); i++) begin
      n_checks++;
      if (acc_who[i] != i % 2) begin
        n_fail++; $display("FAIL contention_order: grant %0d went to r%0d expected r%0d", i, acc_who[i], i % 2);
      end
    end
  endtask

  task automatic test_illegal();
    @(posedge clk); #1;
    r1_valid = 1; r1_op1 = 8'hAA; r1_op2 = 8'h55; r1_opcode = 3'b111; r1_rsp_ready = 0;
    @(negedge clk);
    n_checks++;
    if ({r1_ready, alu_enable} !== 2'b10) begin
      n_fail++; $display("FAIL illegal_accept: ready/en=%b expected 10", {r1_ready, alu_enable});
    end
    @(posedge clk); #1 r1_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({r1_rsp_valid, r1_err, r1_result, alu_enable, r0_rsp_valid} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL illegal_resp: rv=%b err=%b res=%h en=%b rv0=%b expected 1 1 00 0 0",
                           r1_rsp_valid, r1_err, r1_result, alu_enable, r0_rsp_valid);
      end
    end
    r1_rsp_ready = 1;
    @(posedge clk); #1 r1_rsp_ready = 0;
    @(negedge clk);
    n_checks++;
    if (r1_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_consumed: rsp_valid=%b expected 0", r1_rsp_valid);
    end
  endtask

  task automatic test_backpressure_reset();
    @(posedge clk); #1;
    r0_valid = 1; r0_op1 = 8'h21; r0_op2 = 8'h12; r0_opcode = 3'b000; r0_rsp_ready = 0;
    @(posedge clk); #1;
    r0_valid = 0; r1_valid = 1; r1_op1 = 8'h01; r1_op2 = 8'h02; r1_opcode = 3'b000;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({r0_rsp_valid, r0_result, r0_err, r1_ready} !== {1'b1, 8'h33, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL backpressure: rv=%b res=%h err=%b r1_ready=%b expected 1 33 0 0",
                           r0_rsp_valid, r0_result, r0_err, r1_ready);
      end
      @(posedge clk); #1;
    end
    r0_valid = 1;
    rst_n = 0;
    #1;
    n_checks++;
    if ({r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_result, r1_result, r0_err, r1_err,
         alu_operand1, alu_operand2, alu_operation, alu_enable} !== '0) begin
      n_fail++; $display("FAIL midresp_reset: rv0=%b res0=%h en=%b readies=%b%b expected all 0",
                         r0_rsp_valid, r0_result, alu_enable, r0_ready, r1_ready);
    end
    r0_valid = 0; r1_valid = 0; r0_rsp_ready = 1; r1_rsp_ready = 1;
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({r0_rsp_valid, r1_rsp_valid, alu_enable} !== 3'b000) begin
        n_fail++; $display("FAIL stale_response: rv0/rv1/en=%b expected 000", {r0_rsp_valid, r1_rsp_valid, alu_enable});
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    req_t q;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      q.a = 8'($urandom); q.b = 8'($urandom); q.opc = 3'($urandom_range(0, 7)); pend0.push_back(q);
      q.a = 8'($urandom); q.b = 8'($urandom); q.opc = 3'($urandom_range(0, 7)); pend1.push_back(q);
    end
    run_traffic(1'b1, "random");
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic test_perf();
    req_t q;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q.a = 8'($urandom); q.b = 8'($urandom); q.opc = 3'($urandom_range(0, 7)); pend0.push_back(q);
    end
    for (int i = 0; i < 2; i++) begin
      q.a = 8'($urandom); q.b = 8'($urandom); q.opc = 3'($urandom_range(0, 7)); pend1.push_back(q);
    end
    run_traffic(1'b0, "perf");
    @(negedge clk);
    n_checks++;
    if ({r0_count, r1_count} !== {16'd3, 16'd2}) begin
      n_fail++; $display("FAIL perf_counts: got %0d/%0d expected 3/2", r0_count, r1_count);
    end
    force dut.r0_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.r0_cnt_q;
    q.a = 8'h01; q.b = 8'h01; q.opc = 3'b000; pend0.push_back(q);
    run_traffic(1'b0, "perf_wrap");
    @(negedge clk);
    n_checks++;
    if ({r0_count, r1_count} !== {16'd0, 16'd2}) begin
      n_fail++; $display("FAIL perf_wrap: got %h/%0d expected 0000/2", r0_count, r1_count);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_single_op();
    test_sweep();
    test_contention();
    test_illegal();
    test_backpressure_reset();
    test_random();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
